// File: rtl/spi_slave_shifter_if.sv
// Bus bundle between the SPI edge detectors, the shift engine and its word producer/consumer.
// Latency: none (signal grouping only).
// Backpressure: rx side holds until rx_ack; tx side is paced by the tx_latch pulse.
interface spi_slave_shifter_if #(
   parameter int DATA_W = 8
);
   logic              sclk_posedge;
   logic              sclk_negedge;
   logic              cs_fall;
   logic              cs_rise;
   logic              mosi_sync;
   logic [DATA_W-1:0] tx_data;
   logic              rx_ack;
   logic              miso;
   logic              tx_latch;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              rx_overrun;
   logic              frame_err;

   // Shift engine side
   modport slave (
      input  sclk_posedge, sclk_negedge, cs_fall, cs_rise, mosi_sync, tx_data, rx_ack,
      output miso, tx_latch, rx_data, rx_valid, rx_overrun, frame_err
   );

   // Edge detector / producer / consumer side
   modport master (
      output sclk_posedge, sclk_negedge, cs_fall, cs_rise, mosi_sync, tx_data, rx_ack,
      input  miso, tx_latch, rx_data, rx_valid, rx_overrun, frame_err
   );
endinterface

// File: rtl/spi_slave_shifter.sv
// SPI mode-0 slave shift engine: deserializes MOSI into words, serializes tx words onto MISO MSB-first.
// Latency: rx_data/rx_valid 1 clk after the completing SCLK rise; miso 1 clk after cs_fall/SCLK fall; tx_latch combinational.
// Backpressure: rx word held until rx_ack; an unacked word is overwritten (flagged when SPI_SLAVE_OVERRUN_EN is defined).
module spi_slave_shifter #(
   parameter int DATA_W = 8
) (
   input logic               clk,
   input logic               rst_n,
   spi_slave_shifter_if.slave bus
);
   localparam int             CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t            state;
   logic [CNT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] tx_shift;
   // Only DATA_W-1 bits are stored; the last bit is taken straight from mosi_sync on completion.
   logic [DATA_W-2:0] rx_shift;
   logic [DATA_W-1:0] rx_word;
   logic              miso_q;
   logic [DATA_W-1:0] rx_data_q;
   logic              rx_valid_q;
   logic              frame_err_q;
   logic              start;
   logic              word_done;

   assign rx_word = {rx_shift, bus.mosi_sync};

   // Frame start and word completion decode; cs_rise outranks cs_fall, both outrank SCLK pulses
   always_comb begin
      start     = bus.cs_fall & ~bus.cs_rise;
      word_done = (state == SHIFT) & ~bus.cs_rise & ~bus.cs_fall &
                  bus.sclk_posedge & (bit_cnt == LAST_BIT);
   end

   assign bus.tx_latch = start | word_done;

   // Frame FSM with shift registers and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         tx_shift    <= '0;
         rx_shift    <= '0;
         miso_q      <= 1'b0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;
         if (bus.rx_ack) begin
            rx_valid_q <= 1'b0;
         end
         if (bus.cs_rise) begin
            // bit_cnt is always 0 in IDLE, so a stray cs_rise there never flags an error
            frame_err_q <= (bit_cnt != '0);
            state       <= IDLE;
            bit_cnt     <= '0;
            miso_q      <= 1'b0;
         end else if (bus.cs_fall) begin
            // Also covers a restart while already shifting
            state    <= SHIFT;
            bit_cnt  <= '0;
            tx_shift <= bus.tx_data;
            miso_q   <= bus.tx_data[DATA_W-1];
         end else if (state == SHIFT) begin
            if (bus.sclk_posedge) begin
               rx_shift <= rx_word[DATA_W-2:0];
               if (bit_cnt == LAST_BIT) begin
                  rx_data_q  <= rx_word;
                  rx_valid_q <= 1'b1;
                  bit_cnt    <= '0;
                  tx_shift   <= bus.tx_data;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end else if (bus.sclk_negedge) begin
               if (bit_cnt != '0) begin
                  tx_shift <= tx_shift << 1;
                  miso_q   <= tx_shift[DATA_W-2];
               end else begin
                  // Freshly loaded word: keep its MSB on the line for the next rising edge
                  miso_q <= tx_shift[DATA_W-1];
               end
            end
         end
      end
   end

   assign bus.miso      = miso_q;
   assign bus.rx_data   = rx_data_q;
   assign bus.rx_valid  = rx_valid_q;
   assign bus.frame_err = frame_err_q;

`ifdef SPI_SLAVE_OVERRUN_EN
   logic overrun_q;

   // Sticky overrun: a word landed on top of an unacknowledged one; cleared only by rx_ack
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun_q <= 1'b0;
      end else if (word_done && rx_valid_q && !bus.rx_ack) begin
         overrun_q <= 1'b1;
      end else if (bus.rx_ack) begin
         overrun_q <= 1'b0;
      end
   end

   assign bus.rx_overrun = overrun_q;
`else
   assign bus.rx_overrun = 1'b0;
`endif

endmodule
